// File: rtl/cosinos_pkg.sv
// Shared types and constants for the cosinos Taylor-series cosine unit.
package cosinos_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LOAD,
    S_MUL,
    S_SCALE,
    S_FINISH
  } state_t;

  localparam int X_W    = 10;
  localparam int Y_W    = 8;
  localparam int INT_W  = 24;
  localparam int X2_W   = 20;
  localparam int FRAC_W = 16;

  // 1/((2n-1)(2n)) in unsigned Q0.16, indexed by term number n (1..8)
  localparam logic [15:0] RECIP [16] = '{
    16'd0,    16'd32768, 16'd5461, 16'd2185, 16'd1170, 16'd728, 16'd496, 16'd360,
    16'd273,  16'd0,     16'd0,    16'd0,    16'd0,    16'd0,   16'd0,   16'd0
  };

endpackage

// File: rtl/cosinos_datapath.sv
// Term/sum recurrence for the cosine series: x^2 multiply, reciprocal scale,
// threshold compare. Controlled by load/mul/scale strobes from the FSM.
module cosinos_datapath
  import cosinos_pkg::*;
#(
  parameter int MAX_TERMS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     mul_en,
  input  logic                     scale_en,
  input  logic [X_W-1:0]           x,
  input  logic [Y_W-1:0]           y,
  output logic                     stop,
  output logic                     last,
  output logic signed [INT_W-1:0]  sum
);

  logic [Y_W-1:0]                  y_r;
  logic [X2_W-1:0]                 x2;
  logic signed [INT_W-1:0]         term;
  logic signed [INT_W-1:0]         p;
  logic [3:0]                      n;
  logic signed [INT_W+X2_W:0]      prod_mul;
  logic signed [INT_W+FRAC_W:0]    prod_scale;
  logic signed [INT_W-1:0]         t_pos;
  logic signed [INT_W-1:0]         t;
  logic [INT_W-1:0]                t_mag;
  logic [INT_W-1:0]                thr;
  logic                            unused_bits;

  always_comb begin
    prod_mul   = (INT_W+X2_W+1)'(term) * (INT_W+X2_W+1)'($signed({1'b0, x2}));
    prod_scale = (INT_W+FRAC_W+1)'(p) * (INT_W+FRAC_W+1)'($signed({1'b0, RECIP[n]}));
    // bits [39:16] are the floor of the >>>16 shift, truncated to 24 bits
    t_pos      = prod_scale[INT_W+FRAC_W-1:FRAC_W];
    t          = -t_pos;
    t_mag      = t[INT_W-1] ? -t : t;
    thr        = {{(INT_W-Y_W-8){1'b0}}, y_r, 8'd0};
    stop       = (t_mag < thr);
    last       = (n == 4'(MAX_TERMS));
  end

  assign unused_bits = ^{prod_mul[INT_W+X2_W:INT_W+FRAC_W], prod_mul[FRAC_W-1:0],
                         prod_scale[INT_W+FRAC_W], prod_scale[FRAC_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      y_r  <= '0;
      x2   <= '0;
      term <= '0;
      sum  <= '0;
      p    <= '0;
      n    <= '0;
    end else if (load) begin
      y_r  <= y;
      x2   <= X2_W'(x) * X2_W'(x);
      term <= 24'sh010000;
      sum  <= 24'sh010000;
      n    <= 4'd1;
    end else if (mul_en) begin
      p    <= prod_mul[INT_W+FRAC_W-1:FRAC_W];
    end else if (scale_en && !stop) begin
      sum  <= sum + t;
      term <= t;
      if (!last) n <= n + 4'd1;
    end
  end

endmodule

// File: rtl/cosinos_core.sv
// Start/done cosine accelerator: FSM around cosinos_datapath.
// Optional macro COSINOS_SAT_EN saturates the Q2.8 result instead of wrapping.
module cosinos_core
  import cosinos_pkg::*;
#(
  parameter int MAX_TERMS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [X_W-1:0]  x,
  input  logic [Y_W-1:0]  y,
  output logic [1:0]      intpart,
  output logic [7:0]      fracpart,
  output logic            done
);

  state_t                  state;
  logic                    load;
  logic                    mul_en;
  logic                    scale_en;
  logic                    stop;
  logic                    last;
  logic signed [INT_W-1:0] sum;

  function automatic logic [9:0] reduce_q28(input logic signed [15:0] sh);
`ifdef COSINOS_SAT_EN
    if (sh > 16'sd511)       return 10'h1FF;
    else if (sh < -16'sd512) return 10'h200;
    else                     return sh[9:0];
`else
    logic unused_hi;
    unused_hi = ^sh[15:10];
    return sh[9:0];
`endif
  endfunction

  assign load     = (state == S_LOAD);
  assign mul_en   = (state == S_MUL);
  assign scale_en = (state == S_SCALE);

  cosinos_datapath #(.MAX_TERMS(MAX_TERMS)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .mul_en   (mul_en),
    .scale_en (scale_en),
    .x        (x),
    .y        (y),
    .stop     (stop),
    .last     (last),
    .sum      (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      intpart  <= '0;
      fracpart <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_ARMED;
        S_ARMED:  if (!start) state <= S_LOAD;
        S_LOAD: begin
          done  <= 1'b0;
          state <= S_MUL;
        end
        S_MUL:    state <= S_SCALE;
        S_SCALE:  state <= (stop || last) ? S_FINISH : S_MUL;
        S_FINISH: begin
          {intpart, fracpart} <= reduce_q28(16'(sum >>> 8));
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cosinos_core.sv
// Scoreboard bench for cosinos_core: fixed cases, start glitch, mid-run reset, random back-to-back runs.
module tb_cosinos_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] x;
  logic [7:0] y;
  logic [1:0] intpart;
  logic [7:0] fracpart;
  logic       done;

  typedef struct {
    logic [9:0] res;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   prev_done = 1'b0;
  int   rt [1:8] = '{32768, 5461, 2185, 1170, 728, 496, 360, 273};

  always #5 clk = ~clk;

  cosinos_core dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .y        (y),
    .intpart  (intpart),
    .fracpart (fracpart),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int xv, input int yv, output logic [9:0] r, output int lat);
    longint x2, term, sum, p, t, mag;
    int k;
    logic signed [23:0] p24;
    logic signed [15:0] s16;
    x2 = xv * xv; term = 65536; sum = 65536; k = 0;
    for (int n = 1; n <= 8; n++) begin
      p = (term * x2) >>> 16;
      p24 = p[23:0];
      p = p24;
      t = -((p * rt[n]) >>> 16);
      k++;
      mag = (t < 0) ? -t : t;
      if (mag < yv * 256) break;
      sum += t;
      term = t;
    end
    s16 = 16'(sum >>> 8);
    r = s16[9:0];
    lat = 2 + 2 * k;
  endtask

  task automatic run(input logic [9:0] xv, input logic [7:0] yv, input logic [9:0] eres,
                     input int elat, input bit ylate, input bit glitch);
    exp_t e, got;
    int   cnt;
    e.res = eres;
    e.lat = elat;
    sb.push_back(e);
    @(negedge clk); start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    if (!ylate) begin x = xv; y = yv; end
    @(posedge clk);  // LOAD entered on this edge
    cnt = 0;
    @(negedge clk);
    if (ylate) begin x = xv; y = yv; end
    check("done_hold", done, prev_done);
    while (cnt < 100) begin
      @(posedge clk); cnt++;
      @(negedge clk);
      if (cnt == 1) begin
        check("done_drop", done, 0);
        x = 10'($urandom);
        y = 8'($urandom);
        if (glitch) start = 1'b1;
      end
      if (cnt == 2) start = 1'b0;
      if (done) break;
    end
    if (!done) begin
      check("done_timeout", done, 1);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      check("result", {intpart, fracpart}, got.res);
      check("latency", cnt, got.lat);
    end
    prev_done = done;
  endtask

  initial begin
    logic [9:0] mres;
    int         mlat;
    logic [9:0] rx;
    logic [7:0] ry;
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_int", intpart, 0);
    check("rst_frac", fracpart, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    run(10'h180, 8'h80, 10'h3E0, 6, 1'b1, 1'b0);
    run(10'h180, 8'h20, 10'h016, 8, 1'b0, 1'b0);
    run(10'h100, 8'h20, 10'h080, 6, 1'b0, 1'b0);
    run(10'h000, 8'h00, 10'h100, 18, 1'b0, 1'b0);
    run(10'h100, 8'h20, 10'h080, 6, 1'b0, 1'b1);
    run(10'h000, 8'h00, 10'h100, 18, 1'b1, 1'b1);

    // abort a run in flight
    @(negedge clk); start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0; x = 10'h180; y = 8'h00;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_done", done, 0);
    check("midrst_int", intpart, 0);
    check("midrst_frac", fracpart, 0);
    @(negedge clk); rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst_quiet", done, 0);
    prev_done = 1'b0;

    for (int i = 0; i < 5; i++) begin
      rx = 10'($urandom_range(0, 10'h300));
      ry = 8'($urandom_range(0, 255));
      model(int'(rx), int'(ry), mres, mlat);
      run(rx, ry, mres, mlat, i[0], i[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
